systolic_sequencer: RTL and testbench
=====================================

# systolic_sequencer

Job controller for the 4x4 32-bit systolic array. It holds operand matrices A and B, which a host loads through a write port. On `start` it clears the array, then streams A rows west-to-east and B columns north-to-south in the skewed order the array needs, drives the array chip-select and checks the array's `done`. It latches the 16 64-bit results for host readback and sits between the host/bus logic and the array instance.

## Interface
Parameters:
- `DW`, 32, operand width; must match the array port width.
- `RW`, 64, result width.
- `N`, 4, array dimension; fixed at 4, other values unsupported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset; the only reset of this block.
- `wr_en`  in  1  operand write strobe.
- `wr_sel`  in  1  0 = matrix A, 1 = matrix B.
- `wr_addr`  in  4  element index, row*4+col.
- `wr_data`  in  DW  operand value.
- `start`  in  1  job request, level-sampled.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse when results are latched.
- `err`  out  1  sticky; array `done` was missing at the expected cycle.
- `rd_addr`  in  4  result index, row*4+col.
- `rd_data`  out  RW  combinational read of the latched result.
- `arr_rst`  out  1  active-high clear to the array.
- `arr_cs`  out  1  array enable.
- `arr_west0..3`  out  DW  row inputs to array rows 0..3.
- `arr_north0..3`  out  DW  column inputs to array columns 0..3.
- `arr_done`  in  1  array done flag.
- `arr_res0..15`  in  RW  array results, index row*4+col.

## Operation
- States: IDLE -> CLEAR -> FEED -> DRAIN -> IDLE.
- IDLE:
  - `wr_en` writes A/B[wr_addr].
  - `start`=1 moves to CLEAR and sets `busy`; `err` clears on accepted start.
- CLEAR: one cycle with `arr_rst`=1. This zeroes the array accumulators, pipeline registers and done counter. Next state is FEED with step=0.
- FEED: 10 cycles, step t=0..9, `arr_cs`=1.
  - west_i = A[i][t-i] when 0<=t-i<=3, else 0.
  - north_j = B[t-j][j] when 0<=t-j<=3, else 0.
  - After t=9 go to DRAIN.
- DRAIN: one cycle.
  - `arr_cs`=0; all operand outputs are 0.
  - Sample `arr_done`; if 0, set `err`.
  - At the exiting edge, latch all 16 `arr_res`, pulse `done`, clear `busy`, return to IDLE.
- While `busy`=1, `wr_en` and `start` are ignored. Operand storage does not change mid-job.
- `rd_data` returns the last latched results. It is unaffected by a running job until DRAIN completes.
- Result latch width equals RW; no truncation. Overflow wraps in the array and is not flagged.

## Timing
- Every output is registered except `rd_data`.
- Reset values: state IDLE; `busy`, `done`, `err`, `arr_rst`, `arr_cs` = 0; all `arr_west`/`arr_north` = 0; result latches and A/B storage = 0.
- Edge E0 accepts start. Cycle after E0: `arr_rst`=1. E1: first FEED values with `arr_cs`=1. E10: t=9 values. E11: DRAIN. E12: latch, then `done`=1 for the cycle after E12.
- Start-to-done latency is 12 cycles; `busy` is high for exactly 12 cycles.
- `arr_done` is required high during DRAIN: the array counts 10 enabled edges E2..E11.
- `start` held high during `done`: the job is re-accepted on the edge after `done` asserts, i.e. back-to-back jobs with one IDLE cycle.
- `wr_en` in the same cycle `start` is accepted: the write takes effect and the job uses the new value.
- Reset mid-job returns to IDLE immediately.
  - `arr_rst` and `arr_cs` drop to 0, so the array is not cleared by this block.
  - The next job's CLEAR handles array state.

## Structure
- Shared package: state enum (IDLE, CLEAR, FEED, DRAIN), `FEED_STEPS`=10, `N`=4, index helper constants.
- One sub-module, `skew_feeder`, a combinational function of (step, A, B) producing west/north vectors. The controller registers its outputs.
- Operand storage is two 16-entry DW register files. Result storage is a 16-entry RW register file.

## Test plan
- Identity: A=I, B[r][c]=r*4+c+1 -> results equal B (res5=6, res15=16); `done` 12 cycles after start; `err`=0.
- All-ones: A=B=all 1 -> every result = 4. Back-to-back second job with A=all 2 -> every result = 8, proving CLEAR between jobs.
- Skew check: probe `arr_west2` at each FEED step -> 0,0,A[2][0],A[2][1],A[2][2],A[2][3],0,0,0,0.
- Max values: A=B=all 0xFFFFFFFF -> each result = 4*(2^32-1)^2 mod 2^64 = 0xFFFFFFF800000004.
- Writes and start while busy: altered A and a second `start` mid-job -> results match the original A; no extra job starts.
- Reset at step 5, then a new job -> `busy`/`arr_cs` go 0 asynchronously; the new job yields correct results; `err` forced via a stubbed `arr_done`=0 -> `err`=1 until the next start.

Source files
------------

// File: rtl/systolic_sequencer_pkg.sv
// Shared types and constants for the 4x4 systolic array job controller.
package systolic_sequencer_pkg;
    localparam int N          = 4;
    localparam int NN         = N * N;
    localparam int FEED_STEPS = 10;
    localparam int STEP_W     = 4;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FEED_STEPS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_e;

    // Flat register-file index of element (row, col).
    function automatic logic [3:0] idx(input int r, input int c);
        return 4'(r * N + c);
    endfunction
endpackage

// File: rtl/systolic_sequencer_skew.sv
// Combinational skew generator: operand vectors presented to the array edges at one feed step.
module skew_feeder
    import systolic_sequencer_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [STEP_W-1:0]       step,
    input  logic [NN-1:0][DW-1:0]   a,
    input  logic [NN-1:0][DW-1:0]   b,
    output logic [N-1:0][DW-1:0]    west,
    output logic [N-1:0][DW-1:0]    north
);
    // Row i gets A[i][k] and column i gets B[k][i] at step i+k; all else is zero.
    always_comb begin
        west  = '0;
        north = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(step) == i + k) begin
                    west[i]  = a[idx(i, k)];
                    north[i] = b[idx(k, i)];
                end
            end
        end
    end
endmodule

// File: rtl/systolic_sequencer.sv
// Job controller for the 4x4 systolic array: operand storage, skewed feed, result latch.
module systolic_sequencer
    import systolic_sequencer_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 64,
    parameter int N  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [3:0]    rd_addr,
    output logic [RW-1:0] rd_data,
    output logic          arr_rst,
    output logic          arr_cs,
    output logic [DW-1:0] arr_west0,
    output logic [DW-1:0] arr_west1,
    output logic [DW-1:0] arr_west2,
    output logic [DW-1:0] arr_west3,
    output logic [DW-1:0] arr_north0,
    output logic [DW-1:0] arr_north1,
    output logic [DW-1:0] arr_north2,
    output logic [DW-1:0] arr_north3,
    input  logic          arr_done,
    input  logic [RW-1:0] arr_res0,
    input  logic [RW-1:0] arr_res1,
    input  logic [RW-1:0] arr_res2,
    input  logic [RW-1:0] arr_res3,
    input  logic [RW-1:0] arr_res4,
    input  logic [RW-1:0] arr_res5,
    input  logic [RW-1:0] arr_res6,
    input  logic [RW-1:0] arr_res7,
    input  logic [RW-1:0] arr_res8,
    input  logic [RW-1:0] arr_res9,
    input  logic [RW-1:0] arr_res10,
    input  logic [RW-1:0] arr_res11,
    input  logic [RW-1:0] arr_res12,
    input  logic [RW-1:0] arr_res13,
    input  logic [RW-1:0] arr_res14,
    input  logic [RW-1:0] arr_res15
);
    state_e                   state_d, state_q;
    logic [STEP_W-1:0]        step_d, step_q;
    logic [N*N-1:0][DW-1:0]   a_d, a_q, b_d, b_q;
    logic [N*N-1:0][RW-1:0]   res_d, res_q, res_in;
    logic                     busy_d, busy_q, done_d, done_q, err_d, err_q;
    logic                     arr_rst_d, arr_rst_q, arr_cs_d, arr_cs_q;
    logic [N-1:0][DW-1:0]     west_d, west_q, north_d, north_q, feed_west, feed_north;

    assign res_in = {arr_res15, arr_res14, arr_res13, arr_res12, arr_res11, arr_res10,
                     arr_res9, arr_res8, arr_res7, arr_res6, arr_res5, arr_res4,
                     arr_res3, arr_res2, arr_res1, arr_res0};

    // Feeder looks at the step being loaded into the output registers this edge.
    skew_feeder #(.DW(DW)) u_skew (
        .step  (step_d),
        .a     (a_q),
        .b     (b_q),
        .west  (feed_west),
        .north (feed_north)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        arr_rst_d = 1'b0;
        arr_cs_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    if (wr_sel) b_d[wr_addr] = wr_data;
                    else        a_d[wr_addr] = wr_data;
                end
                if (start) begin
                    state_d   = CLEAR;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    arr_rst_d = 1'b1;
                end
            end
            CLEAR: begin
                state_d  = FEED;
                step_d   = '0;
                arr_cs_d = 1'b1;
            end
            FEED: begin
                if (step_q == LAST_STEP) begin
                    state_d = DRAIN;
                end else begin
                    step_d   = step_q + 4'd1;
                    arr_cs_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!arr_done) err_d = 1'b1;
                res_d   = res_in;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        west_d  = arr_cs_d ? feed_west  : '0;
        north_d = arr_cs_d ? feed_north : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            arr_rst_q <= 1'b0;
            arr_cs_q  <= 1'b0;
            west_q    <= '0;
            north_q   <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            arr_rst_q <= arr_rst_d;
            arr_cs_q  <= arr_cs_d;
            west_q    <= west_d;
            north_q   <= north_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign arr_rst    = arr_rst_q;
    assign arr_cs     = arr_cs_q;
    assign arr_west0  = west_q[0];
    assign arr_west1  = west_q[1];
    assign arr_west2  = west_q[2];
    assign arr_west3  = west_q[3];
    assign arr_north0 = north_q[0];
    assign arr_north1 = north_q[1];
    assign arr_north2 = north_q[2];
    assign arr_north3 = north_q[3];
    assign rd_data    = res_q[rd_addr];
endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: behavioural 4x4 array stub, job-timeline model, per-cycle compare.
module tb_systolic_sequencer;
    logic        clk = 0, rst = 0;
    logic        wr_en = 0, wr_sel = 0, start = 0;
    logic [3:0]  wr_addr = 0, rd_addr = 0;
    logic [31:0] wr_data = 0;
    logic        busy, done, err, arr_rst, arr_cs, arr_done;
    logic [63:0] rd_data;
    logic [31:0] west [4];
    logic [31:0] north [4];
    logic [63:0] acc [4][4];
    logic [31:0] ar [4][4], br [4][4], ain [4][4], bin [4][4];
    int          cnt;
    bit          kill = 0;
    int          n_vec = 0, n_bad = 0;
    logic [31:0] probe_w [10];
    logic [31:0] expw [10] = '{0, 0, 11, 12, 13, 14, 0, 0, 0, 0};

    always #5 clk = ~clk;

    systolic_sequencer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done), .err(err),
        .rd_addr(rd_addr), .rd_data(rd_data), .arr_rst(arr_rst), .arr_cs(arr_cs),
        .arr_west0(west[0]), .arr_west1(west[1]), .arr_west2(west[2]), .arr_west3(west[3]),
        .arr_north0(north[0]), .arr_north1(north[1]), .arr_north2(north[2]), .arr_north3(north[3]),
        .arr_done(arr_done),
        .arr_res0(acc[0][0]), .arr_res1(acc[0][1]), .arr_res2(acc[0][2]), .arr_res3(acc[0][3]),
        .arr_res4(acc[1][0]), .arr_res5(acc[1][1]), .arr_res6(acc[1][2]), .arr_res7(acc[1][3]),
        .arr_res8(acc[2][0]), .arr_res9(acc[2][1]), .arr_res10(acc[2][2]), .arr_res11(acc[2][3]),
        .arr_res12(acc[3][0]), .arr_res13(acc[3][1]), .arr_res14(acc[3][2]), .arr_res15(acc[3][3])
    );

    // Output-stationary array stub: operands hop one PE per enabled edge.
    always_comb begin
        ain = '{default: '0};
        bin = '{default: '0};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ain[i][j] = (j == 0) ? west[i]  : ar[i][(j == 0) ? 0 : j - 1];
                bin[i][j] = (i == 0) ? north[j] : br[(i == 0) ? 0 : i - 1][j];
            end
        end
    end

    always @(posedge clk) begin
        if (arr_rst) begin
            cnt <= 0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    acc[i][j] <= '0; ar[i][j] <= '0; br[i][j] <= '0;
                end
        end else if (arr_cs) begin
            cnt <= cnt + 1;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    acc[i][j] <= acc[i][j] + 64'(ain[i][j]) * 64'(bin[i][j]);
                    ar[i][j]  <= ain[i][j];
                    br[i][j]  <= bin[i][j];
                end
        end
    end

    assign arr_done = (cnt == 10) && !kill;

    // Model: k = cycles since the accepted start edge (0 = idle).
    int          k;
    bit          done_m, err_m;
    logic [31:0] mA [16], mB [16];
    logic [63:0] res_m [16];

    function automatic logic [63:0] mm(input int r, input int c);
        logic [63:0] s = 0;
        for (int x = 0; x < 4; x++) s += 64'(mA[r*4+x]) * 64'(mB[x*4+c]);
        return s;
    endfunction

    function automatic logic [31:0] ew(input int i);
        int t = k - 2;
        if (k >= 2 && k <= 11 && t - i >= 0 && t - i <= 3) return mA[i*4 + t - i];
        return 0;
    endfunction

    function automatic logic [31:0] en(input int j);
        int t = k - 2;
        if (k >= 2 && k <= 11 && t - j >= 0 && t - j <= 3) return mB[(t-j)*4 + j];
        return 0;
    endfunction

    initial begin
        k = 0; done_m = 0; err_m = 0;
        for (int i = 0; i < 16; i++) begin mA[i] = 0; mB[i] = 0; res_m[i] = 0; end
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                k = 0; done_m = 0; err_m = 0;
                for (int i = 0; i < 16; i++) begin mA[i] = 0; mB[i] = 0; res_m[i] = 0; end
            end else begin
                done_m = 0;
                if (k == 0) begin
                    if (wr_en) begin
                        if (wr_sel) mB[wr_addr] = wr_data;
                        else        mA[wr_addr] = wr_data;
                    end
                    if (start) begin k = 1; err_m = 0; end
                end else if (k == 12) begin
                    if (!arr_done) err_m = 1;
                    for (int i = 0; i < 16; i++) res_m[i] = mm(i / 4, i % 4);
                    k = 0; done_m = 1;
                end else begin
                    k++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("busy",    64'(busy),    64'(k != 0));
            chk("arr_rst", 64'(arr_rst), 64'(k == 1));
            chk("arr_cs",  64'(arr_cs),  64'(k >= 2 && k <= 11));
            chk("done",    64'(done),    64'(done_m));
            chk("err",     64'(err),     64'(err_m));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("west%0d", i),  64'(west[i]),  64'(ew(i)));
                chk($sformatf("north%0d", i), 64'(north[i]), 64'(en(i)));
            end
            chk("rd_data", rd_data, res_m[rd_addr]);
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wr(input logic s, input logic [3:0] a, input logic [31:0] d);
        wr_en = 1; wr_sel = s; wr_addr = a; wr_data = d;
        step();
        wr_en = 0;
    endtask

    task automatic lit(input string nm, input logic [3:0] a, input logic [63:0] expv);
        rd_addr = a; #1;
        chk(nm, rd_data, expv);
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) begin rd_addr = 4'(a); step(); end
    endtask

    task automatic run_job(input bit hold, input bit meddle, input bit probe);
        int cyc;
        start = 1;
        step();
        wr_en = 0;
        if (!hold) start = 0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (meddle && cyc == 5) begin
                wr_en = 1; wr_sel = 0; wr_addr = 0; wr_data = 777; start = 1;
            end
            step();
            if (meddle && cyc == 5) begin wr_en = 0; start = 0; end
            cyc++;
            if (probe && cyc >= 2 && cyc <= 11) probe_w[cyc-2] = west[2];
        end
        chk("latency", 64'(cyc), 64'd13);
    endtask

    task automatic load_ident();
        for (int i = 0; i < 16; i++) wr(1'b1, 4'(i), 32'(i + 1));
        for (int i = 0; i < 16; i++) wr(1'b0, 4'(i), (i % 5 == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst = 1;
        step();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_cs", 64'(arr_cs), 0);
        lit("rst_rd", 4'd9, 0);

        // Identity; last A element written in the same cycle start is accepted.
        for (int i = 0; i < 16; i++) wr(1'b1, 4'(i), 32'(i + 1));
        for (int i = 0; i < 15; i++) wr(1'b0, 4'(i), (i % 5 == 0) ? 32'd1 : 32'd0);
        wr_en = 1; wr_sel = 0; wr_addr = 15; wr_data = 1;
        run_job(0, 0, 0);
        lit("id_res5", 4'd5, 64'd6);
        lit("id_res15", 4'd15, 64'd16);
        chk("id_err", 64'(err), 0);
        sweep();

        // Skew probe on row 2.
        for (int c = 0; c < 4; c++) wr(1'b0, 4'(8 + c), 32'(11 + c));
        run_job(0, 0, 1);
        for (int t = 0; t < 10; t++) chk($sformatf("skew_t%0d", t), 64'(probe_w[t]), 64'(expw[t]));

        // All ones, then two back-to-back jobs with A = 2.
        for (int i = 0; i < 16; i++) begin wr(1'b0, 4'(i), 1); wr(1'b1, 4'(i), 1); end
        run_job(0, 0, 0);
        lit("ones_res0", 4'd0, 64'd4);
        lit("ones_res10", 4'd10, 64'd4);
        for (int i = 0; i < 16; i++) wr(1'b0, 4'(i), 2);
        run_job(1, 0, 0);
        lit("b2b1_res3", 4'd3, 64'd8);
        run_job(0, 0, 0);
        lit("b2b2_res7", 4'd7, 64'd8);
        sweep();

        // Max operands.
        for (int i = 0; i < 16; i++) begin wr(1'b0, 4'(i), 32'hFFFF_FFFF); wr(1'b1, 4'(i), 32'hFFFF_FFFF); end
        run_job(0, 0, 0);
        lit("max_res0", 4'd0, 64'hFFFF_FFF8_0000_0004);
        lit("max_res15", 4'd15, 64'hFFFF_FFF8_0000_0004);

        // Writes and start while busy are ignored.
        for (int i = 0; i < 16; i++) begin
            wr(1'b0, 4'(i), 32'(100 + i));
            wr(1'b1, 4'(i), (i % 5 == 0) ? 32'd1 : 32'd0);
        end
        run_job(0, 1, 0);
        lit("busywr_res0", 4'd0, 64'd100);
        lit("busywr_res5", 4'd5, 64'd105);
        repeat (3) step();
        chk("no_extra_job", 64'(busy), 0);

        // Asynchronous reset in the middle of FEED step 5.
        start = 1; step(); start = 0;
        repeat (6) step();
        rst = 0; #1;
        chk("rst_mid_busy", 64'(busy), 0);
        chk("rst_mid_cs", 64'(arr_cs), 0);
        step(); rst = 1; step();
        lit("rst_mid_rd", 4'd0, 0);
        load_ident();
        run_job(0, 0, 0);
        lit("post_rst_res5", 4'd5, 64'd6);
        lit("post_rst_res15", 4'd15, 64'd16);

        // Missing array done sets sticky err until the next accepted start.
        kill = 1;
        run_job(0, 0, 0);
        chk("err_set", 64'(err), 1);
        repeat (3) step();
        chk("err_sticky", 64'(err), 1);
        kill = 0;
        run_job(0, 0, 0);
        chk("err_clr", 64'(err), 0);
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
